// File: rtl/conv_pkg.sv
// Shared geometry defaults, pixel type and pointer-width helper for the convolve
// output path.
package conv_pkg;

  localparam int BITS            = 9;
  localparam int KERNEL_SIZE     = 3;
  localparam int IMG_LENGTH      = 16;
  localparam int OUT_DIM         = IMG_LENGTH - KERNEL_SIZE + 1;
  localparam int FRAME_POSITIONS = OUT_DIM * IMG_LENGTH;

  typedef logic [BITS-1:0] pixel_t;

  // Pointer width for a table of 'depth' entries; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int out_dim(input int img_length, input int kernel_size);
    return img_length - kernel_size + 1;
  endfunction

endpackage

// File: rtl/conv_sync_fifo.sv
// Single-clock FIFO with active-low sync reset; a push is accepted while full
// when a pop happens in the same cycle.
module conv_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import conv_pkg::*;

  localparam int AW = ptr_w(DEPTH);
  localparam logic [$clog2(DEPTH):0] FULL_CNT = ($clog2(DEPTH)+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  // Head is read straight from storage; forced to zero while empty so reset shows 0.
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_out_collector.sv
// Collects the convolve pixel stream, drops row-wrap windows and buffers kept pixels.
// Optional CONV_OUT_STATS_EN adds max_pix, the per-frame maximum of kept pixels.
module conv_out_collector #(
  parameter int BITS        = conv_pkg::BITS,
  parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
  parameter int IMG_LENGTH  = conv_pkg::IMG_LENGTH,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [BITS-1:0]               pix_in,
  input  logic                          pix_valid_in,
  output logic [BITS-1:0]               out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          frame_done,
  output logic                          overflow,
  input  logic                          clear_overflow
`ifdef CONV_OUT_STATS_EN
  ,
  output logic [BITS-1:0]               max_pix
`endif
);
  import conv_pkg::*;

  localparam int ROWS = out_dim(IMG_LENGTH, KERNEL_SIZE);
  localparam int CW   = ptr_w(IMG_LENGTH);
  localparam int RW   = ptr_w(ROWS);
  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_LENGTH - 1);
  localparam logic [CW-1:0] COL_KEEP_MAX = CW'(IMG_LENGTH - KERNEL_SIZE);
  localparam logic [RW-1:0] ROW_LAST     = RW'(ROWS - 1);

  logic [CW-1:0] col_p0;
  logic [RW-1:0] row_p0;
  logic          keep;
  logic          pop;
  logic          full;
  logic          empty;
  logic          drop;
  logic          last_pos;

  assign last_pos  = (col_p0 == COL_LAST) && (row_p0 == ROW_LAST);
  assign keep      = pix_valid_in && (col_p0 <= COL_KEEP_MAX);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign drop      = keep && full && !pop;

  // Stage p0: raster position of the incoming pixel
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (pix_valid_in) begin
      if (col_p0 == COL_LAST) begin
        col_p0 <= '0;
        row_p0 <= (row_p0 == ROW_LAST) ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= pix_valid_in && last_pos;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  conv_sync_fifo #(
    .WIDTH (BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (keep),
    .pop     (pop),
    .din     (pix_in),
    .dout    (out_data),
    .full    (full),
    .empty   (empty),
    .count   (fill_level)
  );

`ifdef CONV_OUT_STATS_EN
  logic [BITS-1:0] run_max_p0;
  logic [BITS-1:0] run_next;
  logic            first_pos;

  // Top-left position is always kept, so it restarts the running maximum.
  assign first_pos = (col_p0 == '0) && (row_p0 == '0);

  always_comb begin
    run_next = run_max_p0;
    if (keep && (first_pos || (pix_in > run_max_p0))) run_next = pix_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_max_p0 <= '0;
      max_pix    <= '0;
    end else begin
      run_max_p0 <= run_next;
      if (pix_valid_in && last_pos) max_pix <= run_next;
    end
  end
`endif

endmodule

// File: tb/tb_conv_out_collector.sv
// Randomized self-checking bench for conv_out_collector against a queue-based model;
// max_pix is checked when CONV_OUT_STATS_EN is defined.
module tb_conv_out_collector;
  import conv_pkg::*;

  localparam int DEPTH = 16;
  localparam int IL    = IMG_LENGTH;
  localparam int KS    = KERNEL_SIZE;
  localparam int FRAME = FRAME_POSITIONS;

  logic          clk = 1'b0;
  logic          reset_n;
  pixel_t        pix_in;
  logic          pix_valid_in;
  pixel_t        out_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    fill_level;
  logic          frame_done;
  logic          overflow;
  logic          clear_overflow;
`ifdef CONV_OUT_STATS_EN
  pixel_t        max_pix;
`endif

  conv_out_collector #(
    .BITS        (BITS),
    .KERNEL_SIZE (KS),
    .IMG_LENGTH  (IL),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pix_in         (pix_in),
    .pix_valid_in   (pix_valid_in),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fill_level     (fill_level),
    .frame_done     (frame_done),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
`ifdef CONV_OUT_STATS_EN
    ,
    .max_pix        (max_pix)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position index within the frame, buffered pixels, flags.
  pixel_t q[$];
  int     pos;
  bit     m_ovf;
  bit     m_fd;
  pixel_t m_run;
  pixel_t m_max;
  bit     run_valid;

  task automatic model_clear();
    q.delete();
    pos = 0;
    m_ovf = 0;
    m_fd = 0;
    m_run = '0;
    m_max = '0;
    run_valid = 0;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    pix_valid_in = 1'b0;
    pix_in = '0;
    out_ready = 1'b0;
    clear_overflow = 1'b0;
    model_clear();
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Drive one cycle and advance the model with the same inputs.
  task automatic step(input bit v, input pixel_t d, input bit rdy, input bit clr);
    bit kept;
    bit drop;
    reset_n = 1'b1;
    pix_valid_in = v;
    pix_in = d;
    out_ready = rdy;
    clear_overflow = clr;
    kept = v && ((pos % IL) <= IL - KS);
    if (rdy && q.size() > 0) void'(q.pop_front());
    drop = 0;
    if (kept) begin
      if (q.size() < DEPTH) q.push_back(d);
      else drop = 1;
      if (!run_valid || d > m_run) m_run = d;
      run_valid = 1;
    end
    m_fd = v && (pos == FRAME - 1);
    if (m_fd) begin
      m_max = m_run;
      run_valid = 0;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (v) pos = (pos + 1) % FRAME;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_vec++;
    if (out_data !== 9'h000) begin
      n_err++; $display("FAIL reset_out_data: got %0h expected 0", out_data);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, pixel_t'($urandom), 1'b0, 1'b0);
      n_vec++;
      if (out_valid !== 1'b0 || fill_level !== 5'd0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL idle: got valid=%0b fill=%0d ovf=%0b fd=%0b expected all 0",
                 out_valid, fill_level, overflow, frame_done);
      end
    end
  endtask

  task automatic test_keep_drop();
    pixel_t seen[$];
    pixel_t expv[$];
    int     idx;
    int     fd_cnt;
    int     bad;
    do_reset(1);
    idx = 0;
    fd_cnt = 0;
    for (int i = 0; i < FRAME; i++) if ((i % IL) <= IL - KS) expv.push_back(pixel_t'(i % 256));
    for (int cyc = 0; cyc < 2000 && (idx < FRAME || out_valid); cyc++) begin
      bit v;
      v = (idx < FRAME) && (($urandom % 4) != 0);
      if (out_valid) seen.push_back(out_data);
      step(v, v ? pixel_t'(idx % 256) : pixel_t'($urandom), 1'b1, 1'b0);
      if (v) idx++;
      if (frame_done) fd_cnt++;
      n_vec++;
      if (frame_done !== m_fd) begin
        n_err++; $display("FAIL kd_frame_done: got %0b expected %0b at idx %0d", frame_done, m_fd, idx);
      end
      n_vec++;
      if (fill_level !== 5'(q.size()) || (q.size() > 0 && out_data !== q[0])) begin
        n_err++; $display("FAIL kd_fifo: got fill=%0d data=%0h expected fill=%0d", fill_level, out_data, q.size());
      end
    end
    n_vec++;
    if (seen.size() !== expv.size()) begin
      n_err++; $display("FAIL kd_count: got %0d expected %0d", seen.size(), expv.size());
    end
    bad = 0;
    for (int i = 0; i < seen.size() && i < expv.size(); i++) if (seen[i] !== expv[i]) bad++;
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL kd_order: got %0d wrong values expected 0", bad);
    end
    n_vec++;
    if (fd_cnt != 1) begin
      n_err++; $display("FAIL kd_fd_count: got %0d expected 1", fd_cnt);
    end
  endtask

  task automatic test_overflow();
    pixel_t seen[$];
    int     cnt;
    int     max_fill;
    do_reset(1);
    cnt = 0;
    max_fill = 0;
    while (cnt < 20) begin
      if ((pos % IL) <= IL - KS) begin
        cnt++;
        step(1'b1, pixel_t'(cnt), 1'b0, 1'b0);
      end else begin
        step(1'b1, 9'h1FF, 1'b0, 1'b0);
      end
      if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
    end
    n_vec++;
    if (fill_level !== 5'd16 || max_fill != 16) begin
      n_err++; $display("FAIL ovf_fill: got %0d (max %0d) expected 16", fill_level, max_fill);
    end
    n_vec++;
    if (overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_flag: got %0b expected 1", overflow);
    end
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen.push_back(out_data);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    n_vec++;
    if (seen.size() != 16) begin
      n_err++; $display("FAIL ovf_drain_count: got %0d expected 16", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 16; i++) begin
      n_vec++;
      if (seen[i] !== pixel_t'(i + 1)) begin
        n_err++; $display("FAIL ovf_drain_val[%0d]: got %0h expected %0h", i, seen[i], i + 1);
      end
    end
    n_vec++;
    if (overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky: got %0b expected 1", overflow);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: got %0b expected 0", overflow);
    end
  endtask

  task automatic test_full_pop();
    pixel_t seen[$];
    pixel_t vals[$];
    pixel_t v;
    do_reset(1);
    while (vals.size() < DEPTH) begin
      if ((pos % IL) <= IL - KS) begin
        v = pixel_t'($urandom);
        vals.push_back(v);
        step(1'b1, v, 1'b0, 1'b0);
      end else begin
        step(1'b1, pixel_t'($urandom), 1'b0, 1'b0);
      end
    end
    while ((pos % IL) > IL - KS) step(1'b1, pixel_t'($urandom), 1'b0, 1'b0);
    step(1'b1, 9'h1AB, 1'b1, 1'b0);
    n_vec++;
    if (fill_level !== 5'd16 || overflow !== 1'b0) begin
      n_err++; $display("FAIL fp_state: got fill=%0d ovf=%0b expected 16 0", fill_level, overflow);
    end
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen.push_back(out_data);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    n_vec++;
    if (seen.size() != 16 || seen[seen.size()-1] !== 9'h1AB || seen[0] !== vals[1]) begin
      n_err++; $display("FAIL fp_drain: got n=%0d last=%0h first=%0h expected 16 1ab %0h",
                        seen.size(), seen[seen.size()-1], seen[0], vals[1]);
    end
  endtask

  task automatic test_mid_reset();
    pixel_t seen[$];
    pixel_t expv[$];
    int     idx;
    int     fd_cnt;
    int     bad;
    do_reset(1);
    for (int i = 0; i < 100; i++) step(1'b1, pixel_t'($urandom), (i < 94), 1'b0);
    n_vec++;
    if (fill_level !== 5'd5) begin
      n_err++; $display("FAIL mr_prefill: got %0d expected 5", fill_level);
    end
    do_reset(1);
    n_vec++;
    if (out_valid !== 1'b0 || fill_level !== 5'd0 || frame_done !== 1'b0) begin
      n_err++; $display("FAIL mr_after_reset: got valid=%0b fill=%0d fd=%0b expected 0 0 0",
                        out_valid, fill_level, frame_done);
    end
    idx = 0;
    fd_cnt = 0;
    for (int cyc = 0; cyc < 3000 && (idx < FRAME || out_valid); cyc++) begin
      bit     v;
      bit     rdy;
      pixel_t d;
      v = (idx < FRAME) && ($urandom % 2 == 1);
      rdy = ($urandom % 8) != 0;
      d = pixel_t'($urandom);
      if (v && (idx % IL) <= IL - KS) expv.push_back(d);
      if (out_valid && rdy) seen.push_back(out_data);
      step(v, d, rdy, 1'b0);
      if (v) idx++;
      if (frame_done) fd_cnt++;
    end
    bad = (seen.size() == expv.size()) ? 0 : 1;
    for (int i = 0; i < seen.size() && i < expv.size(); i++) if (seen[i] !== expv[i]) bad++;
    n_vec++;
    if (seen.size() != 196 || bad != 0 || fd_cnt != 1 || overflow !== 1'b0) begin
      n_err++; $display("FAIL mr_frame: got n=%0d bad=%0d fd=%0d ovf=%0b expected 196 0 1 0",
                        seen.size(), bad, fd_cnt, overflow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      bit rdy;
      rdy = ((i / 200) % 2 == 0) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
      step($urandom % 4 != 0, pixel_t'($urandom), rdy, ($urandom % 16) == 0);
      n_vec++;
      if (out_valid !== (q.size() != 0) || fill_level !== 5'(q.size()) ||
          (q.size() > 0 && out_data !== q[0])) begin
        n_err++; $display("FAIL rnd_fifo: got valid=%0b fill=%0d data=%0h expected fill=%0d head=%0h",
                          out_valid, fill_level, out_data, q.size(), (q.size() > 0) ? q[0] : '0);
      end
      n_vec++;
      if (overflow !== m_ovf || frame_done !== m_fd) begin
        n_err++; $display("FAIL rnd_flags: got ovf=%0b fd=%0b expected %0b %0b", overflow, frame_done, m_ovf, m_fd);
      end
`ifdef CONV_OUT_STATS_EN
      n_vec++;
      if (max_pix !== m_max) begin
        n_err++; $display("FAIL rnd_max_pix: got %0h expected %0h", max_pix, m_max);
      end
`endif
    end
  endtask

`ifdef CONV_OUT_STATS_EN
  task automatic test_stats();
    int col;
    int row;
    pixel_t d;
    do_reset(1);
    for (int p = 0; p < FRAME; p++) begin
      col = p % IL;
      row = p / IL;
      if (col > IL - KS)             d = 9'h1FF;
      else if (row == 5 && col == 3) d = 9'h0FF;
      else                           d = 9'h010;
      step(1'b1, d, 1'b1, 1'b0);
    end
    n_vec++;
    if (frame_done !== 1'b1 || max_pix !== 9'h0FF) begin
      n_err++; $display("FAIL stats_max: got fd=%0b max=%0h expected 1 0ff", frame_done, max_pix);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_keep_drop();
    test_overflow();
    test_full_pop();
    test_mid_reset();
`ifdef CONV_OUT_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
